memr_dot_reduce: RTL and testbench
==================================

Name: memr_dot_reduce

Overview:
- Downstream consumer of the residual vector memory (8 lanes × 32 bit per row, combinational read port).
- On a start pulse it sweeps a contiguous row range and drives the memory read address.
- Each returned row is squared lane-wise and the products are summed into one scalar r·r for the solver control FSM.
- Pipelined: one row per clock, fixed drain latency, one-cycle finish pulse.

Parameters:
- element_width, 32, signed lane width in bits (two's complement integer).
- no_of_units, 8, lanes per memory row.
- address_width, 20, width of the memory row address.
- acc_width, 80, accumulator and result width in bits; must be ≥ 2*element_width + 3.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base_address  input  address_width  first row to read; sampled with start.
- length  input  address_width  number of rows to reduce; sampled with start.
- read_address  output  address_width  drives the memory read address.
- memory_output  input  no_of_units*element_width  row data; lane k is bits [k*element_width +: element_width].
- busy  output  1  high in every state other than IDLE.
- result  output  acc_width  signed sum of squares; holds its value until the next accepted start.
- finish  output  1  one-cycle pulse, high for exactly one cycle when result becomes valid.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; read_address=0; result=0; finish=0; busy=0; product and accumulator registers=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and length≠0 → RUN. Load addr←base_address, count←length, acc←0.
  - start=1 and length=0 → DRAIN with zero rows queued. finish rises two edges after the start edge; result=0.
- RUN: each edge registers the no_of_units squared lanes of the current row (stage 1), then addr←addr+1 and count←count−1. When count reaches 1 on the edge, go to DRAIN.
- Stage 2: a combinational adder tree sums the stage-1 products; each edge adds the sum into acc when stage 1 holds a valid row (valid bit tracked alongside the products).
- DRAIN: lasts until the valid pipeline is empty, then → DONE.
- DONE: result←acc, finish=1 for this single cycle, then → IDLE.
- Timing, with start sampled on edge 0:
  - read_address=base after edge 0.
  - Row i's products are registered on edge i+1 and accumulated on edge i+2.
  - finish=1 and result valid after edge L+2.
  - Total latency is L+2 edges.
- Address wrap: addr increments modulo 2^address_width with no error flag.
- start while busy=1 is ignored; the operation in flight is unaffected.
- Reset asserted mid-sweep aborts immediately to reset values. No finish pulse is produced for the aborted sweep.
- Arithmetic:
  - Each lane is a signed element_width-bit value; its square is a 2*element_width-bit unsigned value.
  - Products are zero-extended to acc_width.
  - Accumulation is unsigned modulo 2^acc_width unless the optional feature below is enabled.
- read_address is a registered output with no combinational path from start.

Optional Feature:
- Macro: MEMR_DOT_SATURATE_EN.
- Defined: the accumulator clamps at 2^acc_width−1 instead of wrapping, and an extra output port "saturated" (1 bit) is added.
  - saturated is sticky for the sweep, cleared on accepted start and on reset.
  - It is valid alongside finish and held with result.
- Undefined: modulo wrap accumulation; the saturated port does not exist.

Test Plan:
- Reset then idle: hold reset 3 cycles, release → read_address=0, result=0, busy=0, finish never pulses without start.
- Basic sweep: rows 10..13 each hold lanes {1,2,3,4,5,6,7,8}; start with base=10, length=4 → read_address 10,11,12,13 on consecutive cycles; finish after edge 6; result=4×204=816; busy low on the cycle after finish.
- Signed and extreme values: one row with all lanes 0x80000000, length=1 → result=8×2^62=2^65; finish after edge 3.
- Zero length and busy-start: start with length=0 → finish two edges later, result=0. A second start issued mid-sweep of length=5 is ignored; the first result is still correct.
- Address wrap and abort:
  - With address_width=4, base=14, length=4 → addresses 14,15,0,1.
  - Separately, reset asserted on edge 2 of a length-6 sweep → all outputs return to reset values immediately and no finish pulse occurs.
- Saturation (MEMR_DOT_SATURATE_EN, acc_width=66): 3 rows of all 0x80000000 → result=2^66−1 and saturated=1. Without the macro the result wraps to 2^66 mod 2^66 + 2^65 = 2^65.

Source files
------------

// File: rtl/memr_dot_reduce.sv
// memr_dot_reduce: sweeps a contiguous row range of the residual vector memory,
// squares every lane of each returned row and sums the squares into one scalar (r.r).
// One row per clock, fixed drain of two cycles, single-cycle finish pulse.
// Build option: define MEMR_DOT_SATURATE_EN to clamp the accumulator at its maximum
// and expose a sticky "saturated" flag; left undefined, accumulation wraps.
//
// state | meaning
// IDLE  | waiting for start; start is only sampled here
// RUN   | one row address issued per cycle, returned row squared into stage 1
// DRAIN | two-cycle flush: last products accumulated, pipeline emptied
// DONE  | result captured, finish high for this single cycle
module memr_dot_reduce #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int address_width = 20,
  parameter int acc_width     = 80
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic [address_width-1:0]             length,
  output logic [address_width-1:0]             read_address,
  input  logic [no_of_units*element_width-1:0] memory_output,
  output logic                                 busy,
  output logic [acc_width-1:0]                 result,
  output logic                                 finish
`ifdef MEMR_DOT_SATURATE_EN
  ,
  output logic                                 saturated
`endif
);

  localparam int prod_width = 2 * element_width;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     accept;
  logic [address_width-1:0] addr;
  logic [address_width-1:0] count;
  logic                     drain_cnt;
  logic [prod_width-1:0]    sq   [no_of_units];
  logic [prod_width-1:0]    prod [no_of_units];
  logic                     prod_vld;
  logic [acc_width-1:0]     tree_sum;
  logic [acc_width-1:0]     acc;
`ifdef MEMR_DOT_SATURATE_EN
  logic [acc_width:0]       acc_sum;
  logic                     sat_run;
`endif

  // Squaring the two's-complement lane: sign-extend to the product width so the
  // truncated unsigned product equals the exact square (always < 2^prod_width).
  for (genvar g = 0; g < no_of_units; g++) begin : g_lane
    logic [element_width-1:0] lane;
    logic [prod_width-1:0]    lane_ext;
    assign lane     = memory_output[g*element_width +: element_width];
    assign lane_ext = {{element_width{lane[element_width-1]}}, lane};
    assign sq[g]    = lane_ext * lane_ext;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; DRAIN is a fixed two-cycle flush so a zero-length request
  // has the same L+2 latency as any other.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (length == '0) ? DRAIN : RUN;
        end
      end
      RUN:     if (count == address_width'(1)) state_nxt = DRAIN;
      DRAIN:   if (!drain_cnt && !prod_vld) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Row address and remaining-row down-counter; address wraps modulo 2^address_width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr  <= '0;
      count <= '0;
    end else if (accept) begin
      addr  <= base_address;
      count <= length;
    end else if (state == RUN) begin
      addr  <= addr + address_width'(1);
      count <= count - address_width'(1);
    end
  end

  // Drain timer: preloaded outside DRAIN, counts its single step inside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               drain_cnt <= 1'b1;
    else if (state != DRAIN) drain_cnt <= 1'b1;
    else                     drain_cnt <= 1'b0;
  end

  // Stage 1: register the squared lanes of the row currently addressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_vld <= 1'b0;
      for (int k = 0; k < no_of_units; k++) prod[k] <= '0;
    end else begin
      prod_vld <= (state == RUN);
      if (state == RUN) begin
        for (int k = 0; k < no_of_units; k++) prod[k] <= sq[k];
      end
    end
  end

  // Sum of the stage-1 products, zero-extended; cannot overflow since
  // acc_width >= prod_width + 3.
  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < no_of_units; k++) tree_sum = tree_sum + acc_width'(prod[k]);
  end

`ifdef MEMR_DOT_SATURATE_EN
  assign acc_sum = {1'b0, acc} + {1'b0, tree_sum};

  // Stage 2: clamping accumulation with a sticky overflow flag for the sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      sat_run <= 1'b0;
    end else if (accept) begin
      acc     <= '0;
      sat_run <= 1'b0;
    end else if (prod_vld) begin
      if (acc_sum[acc_width]) begin
        acc     <= '1;
        sat_run <= 1'b1;
      end else begin
        acc     <= acc_sum[acc_width-1:0];
      end
    end
  end

  // Saturation flag published together with the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   saturated <= 1'b0;
    else if (accept)             saturated <= 1'b0;
    else if (state_nxt == DONE)  saturated <= sat_run;
  end
`else
  // Stage 2: wrapping accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         acc <= '0;
    else if (accept)   acc <= '0;
    else if (prod_vld) acc <= acc + tree_sum;
  end
`endif

  // Result capture and finish pulse, both registered on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      finish <= 1'b0;
    end else begin
      finish <= (state_nxt == DONE);
      if (state_nxt == DONE) result <= acc;
    end
  end

  assign read_address = addr;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_memr_dot_reduce.sv
// Bench for memr_dot_reduce: a small memory array, a sweep-level reference model,
// a per-cycle compare process, directed literal cases and randomized sweeps.
module tb_memr_dot_reduce;
  localparam int EW   = 32;
  localparam int NU   = 8;
  localparam int AW   = 4;
  localparam int ACCW = 66;
  localparam int ROWS = 16;
  localparam logic [127:0] ACC_MAX = (128'd1 << ACCW) - 128'd1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AW-1:0]     base_address;
  logic [AW-1:0]     length;
  logic [AW-1:0]     read_address;
  logic [NU*EW-1:0]  memory_output;
  logic              busy;
  logic [ACCW-1:0]   result;
  logic              finish;
`ifdef MEMR_DOT_SATURATE_EN
  logic              saturated;
`endif

  logic [EW-1:0] mem [ROWS][NU];
  int n_checks = 0;
  int n_errors = 0;

  memr_dot_reduce #(
    .element_width(EW), .no_of_units(NU), .address_width(AW), .acc_width(ACCW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address),
    .length(length), .read_address(read_address), .memory_output(memory_output),
    .busy(busy), .result(result), .finish(finish)
`ifdef MEMR_DOT_SATURATE_EN
    , .saturated(saturated)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    memory_output = '0;
    for (int k = 0; k < NU; k++) memory_output[k*EW +: EW] = mem[read_address][k];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact sum of squares over the rows of a sweep, in wide arithmetic.
  function automatic logic [127:0] sweep_total(input int b, input int len);
    logic [127:0] t;
    longint v;
    t = '0;
    for (int i = 0; i < len; i++)
      for (int k = 0; k < NU; k++) begin
        v = longint'($signed(mem[(b + i) % ROWS][k]));
        t = t + 128'(v * v);
      end
    return t;
  endfunction

  function automatic logic [127:0] fold_total(input logic [127:0] t);
`ifdef MEMR_DOT_SATURATE_EN
    return (t > ACC_MAX) ? ACC_MAX : t;
`else
    return t & ACC_MAX;
`endif
  endfunction

  // Reference model: a sweep accepted on edge 0 is busy through edge L+2,
  // finish after edge L+2, row i addressed after edge i.
  logic         m_act, m_fresh;
  int           m_k, m_len, m_base;
  logic [127:0] m_total, m_res;
`ifdef MEMR_DOT_SATURATE_EN
  logic         m_sat;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act <= 1'b0; m_fresh <= 1'b1; m_k <= 0; m_len <= 0; m_base <= 0;
      m_total <= '0; m_res <= '0;
`ifdef MEMR_DOT_SATURATE_EN
      m_sat <= 1'b0;
`endif
    end else if (m_act) begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_len + 2) begin
        m_res <= fold_total(m_total);
`ifdef MEMR_DOT_SATURATE_EN
        m_sat <= (m_total > ACC_MAX);
`endif
      end
      if (m_k + 1 == m_len + 3) m_act <= 1'b0;
    end else if (start) begin
      m_act <= 1'b1; m_fresh <= 1'b0; m_k <= 0;
      m_base <= int'(base_address); m_len <= int'(length);
      m_total <= sweep_total(int'(base_address), int'(length));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", 128'(busy), 128'(m_act));
    chk("finish", 128'(finish), 128'(m_act && (m_k == m_len + 2)));
    if (m_act && (m_k < m_len))
      chk("read_address", 128'(read_address), 128'((m_base + m_k) % ROWS));
    if (m_fresh) chk("read_address_idle", 128'(read_address), 128'd0);
    if (!m_act || (m_k == m_len + 2)) begin
      chk("result", 128'(result), m_res);
`ifdef MEMR_DOT_SATURATE_EN
      chk("saturated", 128'(saturated), 128'(m_sat));
`endif
    end
  end

  int addrs[$];

  task automatic run_sweep(input int b, input int len, input int poke_k, input int abort_k,
                           output int fin_k, output logic [127:0] res);
    fin_k = -1;
    res   = '0;
    addrs.delete();
    @(negedge clk);
    start = 1'b1; base_address = AW'(b); length = AW'(len);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k < len) addrs.push_back(int'(read_address));
      if (finish) begin fin_k = k; res = 128'(result); break; end
      if (k == abort_k) begin
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_finish", 128'(finish), 128'd0);
        chk("abort_read_address", 128'(read_address), 128'd0);
        chk("abort_result", 128'(result), 128'd0);
        break;
      end
      start = (k == poke_k);
      if (k == poke_k) begin
        base_address = AW'($urandom_range(0, ROWS - 1));
        length       = AW'(5);
      end
    end
    start = 1'b0;
    if (fin_k < 0 && abort_k < 0) chk("finish_timeout", 128'd0, 128'd1);
  endtask

  task automatic fill_row(input int r, input int mode);
    for (int k = 0; k < NU; k++)
      mem[r][k] = (mode == 0) ? EW'(k + 1) : 32'h8000_0000;
  endtask

  initial begin
    int           fin;
    int           pulses;
    logic [127:0] res;

    reset = 1'b1; start = 1'b0; base_address = '0; length = '0;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < NU; k++) mem[r][k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_read_address", 128'(read_address), 128'd0);
    chk("idle_result", 128'(result), 128'd0);
    chk("idle_busy", 128'(busy), 128'd0);

    // Basic sweep: 4 rows of {1..8}, each row 204.
    for (int r = 10; r <= 14; r++) fill_row(r, 0);
    run_sweep(10, 4, -1, -1, fin, res);
    chk("basic_fin_edge", 128'(fin), 128'd6);
    chk("basic_result", res, 128'd816);
    for (int i = 0; i < 4; i++) chk("basic_addr", 128'(addrs[i]), 128'(10 + i));
    @(negedge clk);
    chk("basic_busy_after", 128'(busy), 128'd0);

    // Most negative lanes: 8 * 2^62.
    fill_row(5, 1);
    run_sweep(5, 1, -1, -1, fin, res);
    chk("extreme_fin_edge", 128'(fin), 128'd3);
    chk("extreme_result", res, 128'd1 << 65);

    // Zero length.
    run_sweep(3, 0, -1, -1, fin, res);
    chk("zero_fin_edge", 128'(fin), 128'd2);
    chk("zero_result", res, 128'd0);

    // Start while busy is ignored.
    run_sweep(10, 5, 2, -1, fin, res);
    chk("busy_start_fin_edge", 128'(fin), 128'd7);
    chk("busy_start_result", res, 128'd1020);

    // Address wrap.
    fill_row(15, 0); fill_row(0, 0); fill_row(1, 0); fill_row(14, 0);
    run_sweep(14, 4, -1, -1, fin, res);
    chk("wrap_addr0", 128'(addrs[0]), 128'd14);
    chk("wrap_addr1", 128'(addrs[1]), 128'd15);
    chk("wrap_addr2", 128'(addrs[2]), 128'd0);
    chk("wrap_addr3", 128'(addrs[3]), 128'd1);
    chk("wrap_result", res, 128'd816);

    // Abort by reset mid-sweep; no finish afterwards.
    run_sweep(2, 6, -1, 2, fin, res);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (finish) pulses++;
    end
    chk("abort_no_finish", 128'(pulses), 128'd0);

    // Accumulator overflow: 3 * 2^65 against a 66-bit accumulator.
    fill_row(0, 1); fill_row(1, 1); fill_row(2, 1);
    run_sweep(0, 3, -1, -1, fin, res);
    chk("overflow_fin_edge", 128'(fin), 128'd5);
`ifdef MEMR_DOT_SATURATE_EN
    chk("overflow_result", res, ACC_MAX);
    chk("overflow_flag", 128'(saturated), 128'd1);
`else
    chk("overflow_result", res, 128'd1 << 65);
`endif

    // Randomized sweeps checked by the model.
    for (int t = 0; t < 30; t++) begin
      int len;
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < NU; k++)
          case ($urandom_range(0, 7))
            0:       mem[r][k] = 32'h8000_0000;
            1:       mem[r][k] = 32'h7fff_ffff;
            default: mem[r][k] = $urandom;
          endcase
      len = $urandom_range(0, 10);
      run_sweep($urandom_range(0, ROWS - 1), len,
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1, -1, fin, res);
      chk("rand_fin_edge", 128'(fin), 128'(len + 2));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
